// File: rtl/ocm_arb_pkg.sv
// Shared types and constants for the two-port on-chip-memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ocm_arb_pkg;

  localparam int OCM_ADDR_W = 13;
  localparam int OCM_DATA_W = 32;
  localparam int OCM_DEPTH  = 5120;
  localparam int OCM_BE_W   = OCM_DATA_W / 8;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic [OCM_ADDR_W-1:0] address;
    logic [OCM_BE_W-1:0]   byteenable;
    logic                  read;
    logic                  write;
    logic [OCM_DATA_W-1:0] writedata;
  } ocm_req_t;

endpackage

// File: rtl/ocm_arbiter_rr_pick.sv
// Two-way request picker: round-robin on ties when OCM_ARB_ROUND_ROBIN_EN
// is defined, otherwise fixed priority with m0 winning every tie.
// Latency: combinational. Backpressure: losers simply see no grant bit.
// Ports: req[1:0] requests, last = requester granted most recently,
//        grant[1:0] one-hot (or zero when nothing requests).
module ocm_rr_pick
  import ocm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
`ifdef OCM_ARB_ROUND_ROBIN_EN
      // Tie goes to whoever was not served last.
      grant = (last == REQ_M1) ? 2'b01 : 2'b10;
`else
      grant = 2'b01;
`endif
    end
  end

`ifndef OCM_ARB_ROUND_ROBIN_EN
  // Fixed priority has no use for history.
  req_id_t unused_last;
  assign unused_last = last;
`endif

endmodule

// File: rtl/ocm_arbiter.sv
// Shares one single-port OCM (one-cycle read latency) between two Avalon-MM
// requesters; one access per cycle, read data back 1 cycle after acceptance.
// Backpressure: the losing requester sees waitrequest until it is granted.
// Ports: clk/reset_n; m0_*/m1_* Avalon-MM slave ports (address, byteenable,
//        read, write, writedata, waitrequest, readdata, readdatavalid);
//        mem_* memory-wrapper side (address, byteenable, chipselect, write,
//        writedata, clken, readdata).
// Build option: OCM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking
//        (default: fixed priority, m0 first).
module ocm_arbiter
  import ocm_arb_pkg::*;
#(
  // The request struct is sized from the package; keep these at their defaults.
  parameter int ADDR_W = OCM_ADDR_W,
  parameter int DATA_W = OCM_DATA_W,
  parameter int DEPTH  = OCM_DEPTH
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  ocm_req_t   r0, r1, sel_req;
  logic [1:0] req, grant_raw, grant;
  logic       accepted, acc_rd, in_range;
  req_id_t    winner, last_grant;

  logic       rd_pend_q, rd_pend_d;
  req_id_t    rd_owner_q, rd_owner_d;
  logic       rd_oor_q, rd_oor_d;
  logic       clken_q;
  logic [DATA_W-1:0] rd_data;

  assign r0 = '{address: m0_address, byteenable: m0_byteenable, read: m0_read,
                write: m0_write, writedata: m0_writedata};
  assign r1 = '{address: m1_address, byteenable: m1_byteenable, read: m1_read,
                write: m1_write, writedata: m1_writedata};

  assign req = {r1.read | r1.write, r0.read | r0.write};

  ocm_rr_pick u_pick (
    .req   (req),
    .last  (last_grant),
    .grant (grant_raw)
  );

  // Nothing is granted while reset is held, so the memory sees no access.
  assign grant  = reset_n ? grant_raw : 2'b00;
  assign winner = grant[1] ? REQ_M1 : REQ_M0;

  assign m0_waitrequest = ~reset_n | (req[0] & ~grant[0]);
  assign m1_waitrequest = ~reset_n | (req[1] & ~grant[1]);

  assign sel_req  = grant[1] ? r1 : r0;
  assign in_range = {1'b0, sel_req.address} < DEPTH_L;
  assign accepted = |grant;
  // Read and write together counts as a write only.
  assign acc_rd   = accepted & sel_req.read & ~sel_req.write;

  assign mem_address    = sel_req.address;
  assign mem_byteenable = sel_req.byteenable;
  assign mem_writedata  = sel_req.writedata;
  assign mem_write      = accepted & sel_req.write & in_range;
  assign mem_chipselect = accepted & in_range;
  assign mem_clken      = clken_q;

  assign rd_pend_d  = acc_rd;
  assign rd_owner_d = acc_rd ? winner    : rd_owner_q;
  assign rd_oor_d   = acc_rd ? ~in_range : rd_oor_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= REQ_M0;
      rd_oor_q   <= 1'b0;
      clken_q    <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_oor_q   <= rd_oor_d;
      clken_q    <= 1'b1;
    end
  end

`ifdef OCM_ARB_ROUND_ROBIN_EN
  req_id_t last_grant_q, last_grant_d;

  assign last_grant_d = accepted ? winner : last_grant_q;
  assign last_grant   = last_grant_q;

  // Resets to M1 so that m0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant_q <= REQ_M1;
    else          last_grant_q <= last_grant_d;
  end
`else
  assign last_grant = REQ_M1;
`endif

  // Out-of-range reads never touched the memory; return zero instead.
  assign rd_data = rd_oor_q ? '0 : mem_readdata;

  assign m0_readdatavalid = rd_pend_q & (rd_owner_q == REQ_M0);
  assign m1_readdatavalid = rd_pend_q & (rd_owner_q == REQ_M1);
  assign m0_readdata      = m0_readdatavalid ? rd_data : '0;
  assign m1_readdata      = m1_readdatavalid ? rd_data : '0;

endmodule
